// File: rtl/gs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gs_pkg                                                               |
// | Shared encodings for the Goldschmidt divide sequencing controller.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package gs_pkg;

   localparam int ITERS_DEFAULT = 3;
   localparam int PASS_W        = 3;

   localparam logic [1:0] ND_D    = 2'd0;
   localparam logic [1:0] ND_N    = 2'd1;
   localparam logic [1:0] ND_NEWD = 2'd2;
   localparam logic [1:0] ND_NEWN = 2'd3;

   localparam logic K_IA     = 1'b0;
   localparam logic K_REFINE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE_D = 3'd1,
      ST_ISSUE_N = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/gs_pass_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gs_pass_cnt                                                          |
// | Multiply-pass counter: clear, increment, terminal flag at last pass. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module gs_pass_cnt
   import gs_pkg::*;
#(
   parameter int W = PASS_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] last,
   output logic [W-1:0] pass,
   output logic         term
);

   logic [W-1:0] r_pass;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pass <= '0;
      end else if (clr) begin
         r_pass <= '0;
      end else if (inc) begin
         r_pass <= r_pass + W'(1);
      end
   end

   assign pass = r_pass;
   assign term = (r_pass == last);

endmodule
`default_nettype wire

// File: rtl/gs_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gs_div_ctrl                                                          |
// | Sequencer for the 2-stage Goldschmidt divide datapath.               |
// | Option macro: GS_CTRL_ITER_OVERRIDE_EN (per-request pass count).     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module gs_div_ctrl
   import gs_pkg::*;
#(
   parameter int ITERS = ITERS_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
`ifdef GS_CTRL_ITER_OVERRIDE_EN
   input  logic [PASS_W-1:0] iters_i,
`endif
   output logic              in_ready,
   output logic              op_ld,
   output logic              k_sel,
   output logic [1:0]        nd_sel,
   output logic              k_en,
   output logic              en_d,
   output logic              en_n,
   output logic              busy,
   output logic              done
);

   if (ITERS < 1 || ITERS > 7) begin : g_iters_range
      $error("gs_div_ctrl: ITERS must be in 1..7");
   end

   localparam logic [PASS_W-1:0] C_LAST_FIXED = PASS_W'(ITERS);

   state_t              r_state;
   state_t              w_next;
   logic                r_en_d;
   logic                r_en_n;
   logic [PASS_W-1:0]   w_last;
   logic [PASS_W-1:0]   w_pass;
   logic                w_term;
   logic                w_first;
   logic                w_inc;

   assign in_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign op_ld    = start & in_ready;

`ifdef GS_CTRL_ITER_OVERRIDE_EN
   // Pass count is captured with the operands so mid-sequence changes are ignored.
   logic [PASS_W-1:0] r_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last <= C_LAST_FIXED;
      end else if (op_ld) begin
         r_last <= (iters_i == '0) ? PASS_W'(1) : iters_i;
      end
   end

   assign w_last = r_last;
`else
   assign w_last = C_LAST_FIXED;
`endif

   assign w_inc   = (r_state == ST_ISSUE_N) && !w_term;
   assign w_first = (w_pass == '0);

   gs_pass_cnt #(
      .W    (PASS_W)
   ) u_pass_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (op_ld),
      .inc  (w_inc),
      .last (w_last),
      .pass (w_pass),
      .term (w_term)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      k_sel  = K_IA;
      nd_sel = ND_D;
      k_en   = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_ISSUE_D;
         end
         ST_ISSUE_D: begin
            busy   = 1'b1;
            k_en   = 1'b1;
            k_sel  = w_first ? K_IA : K_REFINE;
            nd_sel = w_first ? ND_D : ND_NEWD;
            w_next = ST_ISSUE_N;
         end
         ST_ISSUE_N: begin
            // N of this pass still multiplies by the K loaded with D of the same pass.
            busy   = 1'b1;
            nd_sel = w_first ? ND_N : ND_NEWN;
            w_next = w_term ? ST_DRAIN : ST_ISSUE_D;
         end
         ST_DRAIN: begin
            busy   = 1'b1;
            w_next = ST_DONE;
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = start ? ST_ISSUE_D : ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Write enables trail their issue cycle by one, matching the stage-2 product.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en_d <= 1'b0;
         r_en_n <= 1'b0;
      end else begin
         r_en_d <= (r_state == ST_ISSUE_D);
         r_en_n <= (r_state == ST_ISSUE_N);
      end
   end

   assign en_d = r_en_d;
   assign en_n = r_en_n;

endmodule
`default_nettype wire
